// File: rtl/distribute_1x2_sched.sv
// distribute_1x2_sched: buffers tagged words and issues them to a 1x2 switch under per-branch credits
module distribute_1x2_sched #(
   parameter int DATA_WIDTH     = 32,
   parameter int COMMMAND_WIDTH = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int CREDIT_MAX     = 4,
   parameter bit ALLOW_SPLIT    = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [DATA_WIDTH-1:0]            i_data_bus,
   input  logic [1:0]                       i_dest,
   input  logic [1:0]                       i_credit_return,
   output logic                             o_sw_valid,
   output logic [DATA_WIDTH-1:0]            o_sw_data_bus,
   output logic                             o_sw_en,
   output logic [COMMMAND_WIDTH-1:0]        o_sw_cmd,
   output logic [$clog2(CREDIT_MAX+1)-1:0]  o_credit_hi,
   output logic [$clog2(CREDIT_MAX+1)-1:0]  o_credit_lo,
   output logic                             o_credit_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int AW = PW + 1;
   localparam int CW = $clog2(CREDIT_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);
   localparam logic [AW-1:0] DEPTH = AW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, SPLIT} state_t;

   logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr, count;
   logic [PW-1:0] nxt;
   state_t state;
   logic [1:0] rem, grant, iss;
   logic push, fire, split;

   // Saturating credit update; a return at the ceiling is swallowed (and flagged elsewhere)
   function automatic logic [CW-1:0] cnext(input logic [CW-1:0] c, input logic i, input logic r);
      return (r && !i && c == CMAX) ? c : c - CW'(i) + CW'(r);
   endfunction

   assign count = wptr - rptr;
   assign nxt   = rptr[PW-1:0] + PW'(1);
   assign push  = i_valid && o_ready && i_dest != 2'b00;
   assign grant = rem & {o_credit_hi != '0, o_credit_lo != '0};
   assign fire  = state != IDLE && grant == rem;
   assign split = ALLOW_SPLIT && state == ISSUE && rem == 2'b11 && grant != 2'b00 && !fire;
   assign iss   = fire ? rem : split ? grant : 2'b00;

   // Buffer storage: {payload, dest}; contents need no reset since pointers gate every read
   always_ff @(posedge clk)
      if (push) mem[wptr[PW-1:0]] <= {i_data_bus, i_dest};

   // Pointers, credits, registered switch outputs and the IDLE/ISSUE/SPLIT scheduler
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wptr          <= '0;
         rptr          <= '0;
         o_ready       <= 1'b0;
         state         <= IDLE;
         rem           <= 2'b00;
         o_sw_valid    <= 1'b0;
         o_sw_en       <= 1'b0;
         o_sw_cmd      <= '0;
         o_sw_data_bus <= '0;
         o_credit_hi   <= CMAX;
         o_credit_lo   <= CMAX;
         o_credit_err  <= 1'b0;
      end else begin
         wptr          <= wptr + AW'(push);
         rptr          <= rptr + AW'(fire);
         o_ready       <= !(count == DEPTH || (push && count == DEPTH - AW'(1)));
         o_sw_valid    <= iss != 2'b00;
         o_sw_en       <= iss != 2'b00;
         o_sw_cmd      <= COMMMAND_WIDTH'(iss);
         o_sw_data_bus <= iss != 2'b00 ? mem[rptr[PW-1:0]][DATA_WIDTH+1:2] : '0;
         o_credit_hi   <= cnext(o_credit_hi, iss[1], i_credit_return[1]);
         o_credit_lo   <= cnext(o_credit_lo, iss[0], i_credit_return[0]);
         o_credit_err  <= o_credit_err
                          || (i_credit_return[1] && !iss[1] && o_credit_hi == CMAX)
                          || (i_credit_return[0] && !iss[0] && o_credit_lo == CMAX);
         if (state == IDLE) begin
            if (count != '0) begin
               state <= ISSUE;
               rem   <= mem[rptr[PW-1:0]][1:0];
            end
         end else if (fire) begin
            state <= count > AW'(1) ? ISSUE : IDLE;
            rem   <= mem[nxt][1:0];
         end else if (split) begin
            state <= SPLIT;
            rem   <= rem & ~grant;
         end
      end
endmodule

// File: tb/tb_distribute_1x2_sched.sv
// tb_distribute_1x2_sched: directed checks of the credit scheduler, split and no-split variants side by side
module tb_distribute_1x2_sched;
   logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0;
   logic [31:0] i_data_bus = '0;
   logic [1:0]  i_dest = '0, i_credit_return = '0;
   logic        s_ready, s_valid, s_en, s_err, n_ready, n_valid, n_en, n_err;
   logic [31:0] s_data, n_data;
   logic [1:0]  s_cmd, n_cmd;
   logic [2:0]  s_hi, s_lo, n_hi, n_lo;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   distribute_1x2_sched #(.ALLOW_SPLIT(1'b1)) u_s (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(s_ready), .i_data_bus(i_data_bus),
      .i_dest(i_dest), .i_credit_return(i_credit_return), .o_sw_valid(s_valid),
      .o_sw_data_bus(s_data), .o_sw_en(s_en), .o_sw_cmd(s_cmd), .o_credit_hi(s_hi),
      .o_credit_lo(s_lo), .o_credit_err(s_err));

   distribute_1x2_sched #(.ALLOW_SPLIT(1'b0)) u_n (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(n_ready), .i_data_bus(i_data_bus),
      .i_dest(i_dest), .i_credit_return(i_credit_return), .o_sw_valid(n_valid),
      .o_sw_data_bus(n_data), .o_sw_en(n_en), .o_sw_cmd(n_cmd), .o_credit_hi(n_hi),
      .o_credit_lo(n_lo), .o_credit_err(n_err));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_s(input string tag, input logic v, input logic [1:0] cmd, input logic [31:0] d);
      chk({tag, ".s_valid"}, s_valid, v);
      chk({tag, ".s_en"}, s_en, v);
      chk({tag, ".s_cmd"}, s_cmd, cmd);
      chk({tag, ".s_data"}, s_data, d);
   endtask

   task automatic exp_n(input string tag, input logic v, input logic [1:0] cmd, input logic [31:0] d);
      chk({tag, ".n_valid"}, n_valid, v);
      chk({tag, ".n_en"}, n_en, v);
      chk({tag, ".n_cmd"}, n_cmd, cmd);
      chk({tag, ".n_data"}, n_data, d);
   endtask

   task automatic put(input logic [31:0] d, input logic [1:0] dst);
      i_valid    = 1'b1;
      i_data_bus = d;
      i_dest     = dst;
   endtask

   task automatic do_reset;
      i_valid         = 1'b0;
      i_credit_return = 2'b00;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      // reset applied before any clock edge
      #2 rst = 1'b0;
      #1;
      exp_s("rst0", 1'b0, 2'b00, 32'h0);
      chk("rst0.ready", s_ready, 1'b0);
      chk("rst0.hi", s_hi, 3'd4);
      chk("rst0.lo", s_lo, 3'd4);
      chk("rst0.err", s_err, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("rel.ready", s_ready, 1'b1);

      // single duplicate word: issue two edges after acceptance
      put(32'hA5A5A5A5, 2'b11);
      tick();
      i_valid = 1'b0;
      tick();
      chk("t1.early", s_valid, 1'b0);
      tick();
      exp_s("t1.iss", 1'b1, 2'b11, 32'hA5A5A5A5);
      chk("t1.hi", s_hi, 3'd3);
      chk("t1.lo", s_lo, 3'd3);
      tick();
      exp_s("t1.idle", 1'b0, 2'b00, 32'h0);
      i_credit_return = 2'b11;
      tick();
      i_credit_return = 2'b00;
      chk("t1.hi_back", s_hi, 3'd4);
      chk("t1.lo_back", s_lo, 3'd4);
      chk("t1.err", s_err, 1'b0);

      // dest=00 is accepted and dropped
      put(32'hDEAD0000, 2'b00);
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      chk("drop.s_valid", s_valid, 1'b0);
      chk("drop.n_valid", n_valid, 1'b0);
      chk("drop.ready", s_ready, 1'b1);

      // drain low credits, fifth low word stalls until a return
      do_reset();
      put(32'd1, 2'b01); tick();
      put(32'd2, 2'b01); tick();
      put(32'd3, 2'b01); tick();
      exp_s("t2.w1", 1'b1, 2'b01, 32'd1);
      put(32'd4, 2'b01); tick();
      exp_s("t2.w2", 1'b1, 2'b01, 32'd2);
      put(32'd5, 2'b01); tick();
      exp_s("t2.w3", 1'b1, 2'b01, 32'd3);
      i_valid = 1'b0;
      tick();
      exp_s("t2.w4", 1'b1, 2'b01, 32'd4);
      chk("t2.lo0", s_lo, 3'd0);
      chk("t2.hi4", s_hi, 3'd4);
      tick();
      exp_s("t2.stall", 1'b0, 2'b00, 32'h0);
      i_credit_return = 2'b01;
      tick();
      i_credit_return = 2'b00;
      chk("t2.ret_stall", s_valid, 1'b0);
      chk("t2.lo1", s_lo, 3'd1);
      tick();
      exp_s("t2.w5", 1'b1, 2'b01, 32'd5);
      chk("t2.lo_end", s_lo, 3'd0);

      // split versus no-split with lo=0, hi=2
      do_reset();
      put(32'd1, 2'b11); tick();
      put(32'd2, 2'b11); tick();
      put(32'd3, 2'b01); tick();
      exp_s("t3.w1", 1'b1, 2'b11, 32'd1);
      put(32'd4, 2'b01); tick();
      put(32'h0000C0DE, 2'b11); tick();
      i_valid = 1'b0;
      tick();
      exp_s("t3.w4", 1'b1, 2'b01, 32'd4);
      chk("t3.lo0", s_lo, 3'd0);
      chk("t3.hi2", s_hi, 3'd2);
      tick();
      exp_s("t3.split_hi", 1'b1, 2'b10, 32'h0000C0DE);
      chk("t3.s_hi1", s_hi, 3'd1);
      exp_n("t3.nosplit_wait", 1'b0, 2'b00, 32'h0);
      chk("t3.n_hi2", n_hi, 3'd2);
      tick();
      exp_s("t3.split_wait", 1'b0, 2'b00, 32'h0);
      i_credit_return = 2'b01;
      tick();
      i_credit_return = 2'b00;
      chk("t3.s_ret", s_valid, 1'b0);
      chk("t3.n_ret", n_valid, 1'b0);
      chk("t3.s_lo1", s_lo, 3'd1);
      chk("t3.n_lo1", n_lo, 3'd1);
      tick();
      exp_s("t3.split_lo", 1'b1, 2'b01, 32'h0000C0DE);
      exp_n("t3.dup", 1'b1, 2'b11, 32'h0000C0DE);
      chk("t3.s_lo_end", s_lo, 3'd0);
      chk("t3.n_hi_end", n_hi, 3'd1);
      chk("t3.n_lo_end", n_lo, 3'd0);
      tick();
      exp_s("t3.done", 1'b0, 2'b00, 32'h0);

      // fill the buffer with credits exhausted, then free one slot
      do_reset();
      put(32'h11, 2'b11); tick();
      put(32'h12, 2'b11); tick();
      put(32'h13, 2'b11); tick();
      put(32'h14, 2'b11); tick();
      put(32'hB1, 2'b10); tick();
      put(32'hB2, 2'b10); tick();
      chk("t5.hi0", s_hi, 3'd0);
      chk("t5.lo0", s_lo, 3'd0);
      chk("t5.ready_a", s_ready, 1'b1);
      put(32'hB3, 2'b10); tick();
      chk("t5.ready_b", s_ready, 1'b1);
      put(32'hB4, 2'b10); tick();
      chk("t5.full", s_ready, 1'b0);
      put(32'hB5, 2'b10); tick();
      chk("t5.full_hold", s_ready, 1'b0);
      chk("t5.stall", s_valid, 1'b0);
      i_credit_return = 2'b10;
      tick();
      i_credit_return = 2'b00;
      chk("t5.hi1", s_hi, 3'd1);
      chk("t5.ret_stall", s_valid, 1'b0);
      tick();
      exp_s("t5.b1", 1'b1, 2'b10, 32'hB1);
      chk("t5.hi_end", s_hi, 3'd0);
      chk("t5.ready_pop", s_ready, 1'b0);
      tick();
      chk("t5.ready_up", s_ready, 1'b1);
      chk("t5.no_iss", s_valid, 1'b0);
      tick();
      chk("t5.refull", s_ready, 1'b0);
      i_valid = 1'b0;

      // asynchronous reset while a word is on the switch outputs
      i_credit_return = 2'b10;
      tick();
      i_credit_return = 2'b00;
      tick();
      exp_s("t6.b2", 1'b1, 2'b10, 32'hB2);
      #2 rst = 1'b0;
      #1;
      exp_s("t6.async", 1'b0, 2'b00, 32'h0);
      chk("t6.ready", s_ready, 1'b0);
      chk("t6.hi", s_hi, 3'd4);
      chk("t6.lo", s_lo, 3'd4);
      tick();
      rst = 1'b1;
      tick();
      chk("t6.rel_ready", s_ready, 1'b1);
      tick();
      tick();
      chk("t6.empty", s_valid, 1'b0);

      // return at the ceiling saturates and latches the error
      i_credit_return = 2'b11;
      tick();
      i_credit_return = 2'b00;
      chk("t6.sat_hi", s_hi, 3'd4);
      chk("t6.sat_lo", s_lo, 3'd4);
      chk("t6.err", s_err, 1'b1);
      chk("t6.n_err", n_err, 1'b1);
      tick();
      chk("t6.err_sticky", s_err, 1'b1);

      // a fresh word comes out first, proving nothing stale survived reset
      put(32'h77, 2'b01);
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      exp_s("t6.fresh", 1'b1, 2'b01, 32'h77);
      rst = 1'b0;
      #1;
      chk("t6.err_clr", s_err, 1'b0);
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/distribute_1x2_sched.md
Name: distribute_1x2_sched

Overview:
- Scheduler/controller in front of one distribute_1x2_seq switch.
- Buffers incoming words tagged with a 2-bit destination mask, tracks per-branch downstream credits, and drives the switch's i_valid/i_data_bus/i_en/i_cmd.
- Only issues a branch when that branch has credit.
- Optionally splits a duplicate request into two single-branch issues when only one branch has credit.

Parameters:
- DATA_WIDTH, 32, payload width; matches the switch DATA_WIDTH.
- COMMMAND_WIDTH, 2, switch command width; fixed at 2.
- FIFO_DEPTH, 4, input buffer entries; power of two, ≥2.
- CREDIT_MAX, 4, initial and maximum credits per branch; ≥1.
- ALLOW_SPLIT, 1, 1 = partial issue of a 2'b11 request permitted; 0 = wait for both credits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  upstream may transfer this cycle.
- i_data_bus  in  DATA_WIDTH  upstream payload.
- i_dest  in  2  destination mask; bit1 = high branch, bit0 = low branch.
- i_credit_return  in  2  per-branch credit return pulse; bit1 = high, bit0 = low.
- o_sw_valid  out  1  to switch i_valid.
- o_sw_data_bus  out  DATA_WIDTH  to switch i_data_bus.
- o_sw_en  out  1  to switch i_en.
- o_sw_cmd  out  COMMMAND_WIDTH  to switch i_cmd; 01 = low, 10 = high, 11 = duplicate.
- o_credit_hi  out  clog2(CREDIT_MAX+1)  current high-branch credits.
- o_credit_lo  out  clog2(CREDIT_MAX+1)  current low-branch credits.
- o_credit_err  out  1  sticky: a credit was returned while already at CREDIT_MAX.

Behaviour:
Reset (rst=0, takes effect immediately, no clock needed):
- FIFO empty, FSM = IDLE.
- o_ready=0; o_sw_valid=0, o_sw_en=0, o_sw_cmd=00, o_sw_data_bus=0.
- Credits = CREDIT_MAX each; o_credit_err=0.
- On release: o_ready=1 from the first clock edge.
- Reset mid-operation discards all buffered and partially issued words.

Enqueue:
- Transfer when i_valid & o_ready. o_ready = !full, registered. A pop in the same cycle does not raise o_ready.
- i_dest=00 transfers are accepted and silently dropped; no FIFO entry.
- Otherwise the entry {data, dest} is written at the write pointer. Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.

Head register rem[1:0]:
- Loaded with the head entry's dest when a fresh entry becomes head.

Per-cycle grant:
- grant = rem & {credit_hi!=0, credit_lo!=0}.

FSM:
- IDLE: FIFO empty. Switch outputs idle. Moves to ISSUE the cycle after the FIFO becomes non-empty.
- ISSUE (rem = full dest):
  - grant==rem → issue rem, pop, then go to ISSUE (FIFO non-empty) or IDLE.
  - ALLOW_SPLIT=1, rem=11, grant!=0 → issue grant, rem &= ~grant, go to SPLIT.
  - Otherwise stall.
- SPLIT: issues the remaining branch once it has credit, then pops; next state as in ISSUE.
- Issue: registered outputs next cycle: o_sw_valid=1, o_sw_en=1, o_sw_cmd=issued mask, o_sw_data_bus=head data.
- At most one issue per cycle.
- Stall or idle cycle: o_sw_valid=0, o_sw_en=0, o_sw_cmd=00, o_sw_data_bus=0.
- Latency: accepted word into an empty FIFO with credits available → o_sw_valid exactly 2 cycles later. Back-to-back entries with credit issue every cycle.

Credits:
- Per branch, each cycle: next = cur − issued_bit + return_bit.
- Issue and return in the same cycle → unchanged.
- Return at CREDIT_MAX with no issue → saturate at CREDIT_MAX, set o_credit_err (cleared only by reset).
- An issued bit never occurs at 0 credits, because grant masks it.

Ordering:
- Strict FIFO order; no bypass.
- A stalled head blocks later entries even if their branch has credit.

Test Plan:
1. Reset with rst=0, then release; enqueue D=0xA5A5A5A5, dest=11 → 2 cycles later o_sw_valid=1, o_sw_cmd=11, o_sw_data=0xA5A5A5A5; both credits 4→3.
2. Drain low credits with 4 dest=01 words, no returns; 5th word dest=01 → stalls, o_sw_en=0. Pulse i_credit_return=01 → issues next cycle+1, o_credit_lo ends 0.
3. ALLOW_SPLIT=1, credit_lo=0, credit_hi=2; enqueue dest=11 → cmd=10 issued, FSM SPLIT. Return low credit → cmd=01 issued with same data, then pop.
4. ALLOW_SPLIT=0, same setup → no issue until low credit returns, then a single cmd=11.
5. Hold i_valid=1 with credits all 0 → 4 words accepted, o_ready=0. Return one high credit with head dest=10 → pop; o_ready=1 the following cycle.
6. Assert i_credit_return=11 at CREDIT_MAX → credits stay 4, o_credit_err=1. Assert rst=0 mid-stream → all outputs 0 asynchronously, FIFO empty after release.
